// File: rtl/pe_cluster.sv
// Row-stationary convolution cluster: K x X_dim MAC array fed from weight and
// activation scratchpads; each accepted start produces one output row.
module pe_cluster #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 9,
    parameter int kernel_size = 3,
    parameter int act_size    = 5,
    parameter int X_dim       = 3,
    parameter int Y_dim       = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] act_in,
    input  logic [DATA_WIDTH-1:0] filt_in,
    input  logic                  load_en_wght,
    input  logic                  load_en_act,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] pe_out [X_dim-1:0],
    output logic                  compute_done,
    output logic                  load_done
);
    // state     | meaning
    // S_IDLE    | waiting for a start edge (loads allowed)
    // S_COMPUTE | K MAC cycles, one filter column j per cycle
    // S_WRITEBACK | vertical psum reduction into pe_out, advance row

    localparam int KK  = kernel_size * kernel_size;
    localparam int AA  = act_size * act_size;
    localparam int WIW = (KK > 1) ? $clog2(KK) : 1;
    localparam int AIW = (AA > 1) ? $clog2(AA) : 1;

    localparam logic [ADDR_WIDTH-1:0] LP_W_LAST = ADDR_WIDTH'(KK - 1);
    localparam logic [ADDR_WIDTH-1:0] LP_A_LAST = ADDR_WIDTH'(AA - 1);
    localparam logic [ADDR_WIDTH-1:0] LP_J_LAST = ADDR_WIDTH'(kernel_size - 1);
    localparam logic [ADDR_WIDTH-1:0] LP_R_LAST = ADDR_WIDTH'(act_size - kernel_size);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COMPUTE   = 2'd1,
        S_WRITEBACK = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_WIDTH-1:0] r_wght [KK];
    logic [DATA_WIDTH-1:0] r_act  [AA];

    logic                  r_wld_busy;
    logic                  r_ald_busy;
    logic [ADDR_WIDTH-1:0] r_wld_cnt;
    logic [ADDR_WIDTH-1:0] r_ald_cnt;
    logic                  r_wght_ok;
    logic                  r_act_ok;
    logic                  r_load_done;

    logic                  w_wld_start;
    logic                  w_ald_start;
    logic                  w_wght_we;
    logic                  w_act_we;
    logic [ADDR_WIDTH-1:0] w_wght_addr;
    logic [ADDR_WIDTH-1:0] w_act_addr;
    logic                  w_act_fin;

    logic                  r_start_d;
    logic                  w_start_rise;
    logic                  w_accept;
    logic                  w_mac_en;
    logic                  w_wb_en;

    logic [ADDR_WIDTH-1:0] r_j;
    logic [ADDR_WIDTH-1:0] r_row;
    logic [DATA_WIDTH-1:0] r_psum    [Y_dim][X_dim];
    logic [DATA_WIDTH-1:0] w_prod    [Y_dim][X_dim];
    logic [DATA_WIDTH-1:0] w_col_sum [X_dim];
    logic [DATA_WIDTH-1:0] r_pe_out  [X_dim-1:0];
    logic                  r_done;

    // Loaders only start from an idle FSM; an in-flight burst always completes.
    assign w_wld_start  = load_en_wght & ~r_wld_busy & (r_state == S_IDLE);
    assign w_ald_start  = load_en_act  & ~r_ald_busy & (r_state == S_IDLE);
    assign w_wght_we    = ~reset & (w_wld_start | r_wld_busy);
    assign w_act_we     = ~reset & (w_ald_start | r_ald_busy);
    assign w_wght_addr  = r_wld_busy ? r_wld_cnt : '0;
    assign w_act_addr   = r_ald_busy ? r_ald_cnt : '0;
    assign w_act_fin    = (r_ald_busy && (r_ald_cnt == LP_A_LAST)) ||
                          (w_ald_start && (LP_A_LAST == '0));
    assign w_start_rise = start & ~r_start_d;

    always_ff @(posedge clk) begin
        if (w_wght_we) begin
            r_wght[WIW'(w_wght_addr)] <= filt_in;
        end
        if (w_act_we) begin
            r_act[AIW'(w_act_addr)] <= act_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wld_busy <= 1'b0;
            r_wld_cnt  <= '0;
            r_wght_ok  <= 1'b0;
            r_ald_busy <= 1'b0;
            r_ald_cnt  <= '0;
            r_act_ok   <= 1'b0;
        end else begin
            if (r_wld_busy) begin
                if (r_wld_cnt == LP_W_LAST) begin
                    r_wld_busy <= 1'b0;
                    r_wght_ok  <= 1'b1;
                end else begin
                    r_wld_cnt <= r_wld_cnt + 1'b1;
                end
            end else if (w_wld_start) begin
                if (LP_W_LAST == '0) begin
                    r_wght_ok <= 1'b1;
                end else begin
                    r_wld_busy <= 1'b1;
                    r_wld_cnt  <= ADDR_WIDTH'(1);
                end
            end

            if (r_ald_busy) begin
                if (r_ald_cnt == LP_A_LAST) begin
                    r_ald_busy <= 1'b0;
                    r_act_ok   <= 1'b1;
                end else begin
                    r_ald_cnt <= r_ald_cnt + 1'b1;
                end
            end else if (w_ald_start) begin
                if (LP_A_LAST == '0) begin
                    r_act_ok <= 1'b1;
                end else begin
                    r_ald_busy <= 1'b1;
                    r_ald_cnt  <= ADDR_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_mac_en    = 1'b0;
        w_wb_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_rise && r_load_done) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                w_mac_en = 1'b1;
                if (r_j == LP_J_LAST) begin
                    w_state_nxt = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                w_wb_en     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // r_j and r_row stay in range at all times, so these reads never leave the arrays.
    always_comb begin
        for (int i = 0; i < Y_dim; i++) begin
            for (int c = 0; c < X_dim; c++) begin
                w_prod[i][c] = r_wght[WIW'(i * kernel_size + int'(r_j))] *
                               r_act[AIW'((int'(r_row) + i) * act_size + c + int'(r_j))];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < X_dim; c++) begin
            w_col_sum[c] = '0;
            for (int i = 0; i < Y_dim; i++) begin
                w_col_sum[c] = w_col_sum[c] + r_psum[i][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_start_d   <= 1'b0;
            r_load_done <= 1'b0;
            r_done      <= 1'b0;
            r_j         <= '0;
            r_row       <= '0;
            for (int i = 0; i < Y_dim; i++) begin
                for (int c = 0; c < X_dim; c++) begin
                    r_psum[i][c] <= '0;
                end
            end
            for (int c = 0; c < X_dim; c++) begin
                r_pe_out[c] <= '0;
            end
        end else begin
            r_start_d   <= start;
            r_load_done <= r_wght_ok & r_act_ok;
            r_done      <= w_wb_en;

            if (w_accept) begin
                r_j <= '0;
                for (int i = 0; i < Y_dim; i++) begin
                    for (int c = 0; c < X_dim; c++) begin
                        r_psum[i][c] <= '0;
                    end
                end
            end else if (w_mac_en) begin
                r_j <= (r_j == LP_J_LAST) ? '0 : r_j + 1'b1;
                for (int i = 0; i < Y_dim; i++) begin
                    for (int c = 0; c < X_dim; c++) begin
                        r_psum[i][c] <= r_psum[i][c] + w_prod[i][c];
                    end
                end
            end

            if (w_wb_en) begin
                for (int c = 0; c < X_dim; c++) begin
                    r_pe_out[X_dim-1-c] <= w_col_sum[c];
                end
                r_row <= (r_row == LP_R_LAST) ? '0 : r_row + 1'b1;
            end

            // A fresh activation map always restarts at output row 0.
            if (w_act_fin) begin
                r_row <= '0;
            end
        end
    end

    assign pe_out       = r_pe_out;
    assign compute_done = r_done;
    assign load_done    = r_load_done;

endmodule

// File: tb/tb_pe_cluster.sv
// Directed bench for pe_cluster: expected rows are pushed to a scoreboard when
// start is driven and popped by a monitor on each compute_done pulse.
module tb_pe_cluster;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] act_in;
    logic [15:0] filt_in;
    logic        load_en_wght;
    logic        load_en_act;
    logic        start;
    logic [15:0] pe_out [2:0];
    logic        compute_done;
    logic        load_done;

    pe_cluster dut (
        .clk          (clk),
        .reset        (reset),
        .act_in       (act_in),
        .filt_in      (filt_in),
        .load_en_wght (load_en_wght),
        .load_en_act  (load_en_act),
        .start        (start),
        .pe_out       (pe_out),
        .compute_done (compute_done),
        .load_done    (load_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x2;
        logic [15:0] x1;
        logic [15:0] x0;
        int          at;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          r_m   = 0;
    logic [15:0] wm [9];
    logic [15:0] am [25];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_out(input int r, input int c);
        logic [15:0] acc;
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc = acc + wm[i*3+j] * am[(r+i)*5 + c + j];
            end
        end
        return acc;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Push the model's next row; start must be sampled at the next edge.
    task automatic push_exp(input bit use_const, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c);
        exp_t e;
        e.x2 = use_const ? a : ref_out(r_m, 0);
        e.x1 = use_const ? b : ref_out(r_m, 1);
        e.x0 = use_const ? c : ref_out(r_m, 2);
        e.at = cyc + 1 + 4;
        sb.push_back(e);
        r_m = (r_m == 2) ? 0 : r_m + 1;
    endtask

    task automatic do_start(input bit expect_done, input bit use_const, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] c);
        if (expect_done) push_exp(use_const, a, b, c);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(6);
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic load_w(input bit ones);
        for (int n = 0; n < 9; n++) begin
            wm[n]        = ones ? 16'hFFFF : 16'(n + 1);
            load_en_wght = (n == 0);
            filt_in      = wm[n];
            tick(1);
        end
        load_en_wght = 1'b0;
    endtask

    task automatic load_a(input bit ones);
        for (int n = 0; n < 25; n++) begin
            am[n]       = ones ? 16'hFFFF : 16'(n + 1);
            load_en_act = (n == 0);
            act_in      = am[n];
            tick(1);
        end
        load_en_act = 1'b0;
        r_m = 0;
    endtask

    always @(posedge clk) begin
        #1;
        if (compute_done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.at);
                chk("pe_out2", pe_out[2], e.x2);
                chk("pe_out1", pe_out[1], e.x1);
                chk("pe_out0", pe_out[0], e.x0);
            end
        end
    end

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        load_en_wght = 1'b0;
        load_en_act  = 1'b0;
        act_in       = '0;
        filt_in      = '0;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst_pe_out2", pe_out[2], 0);
        chk("rst_pe_out1", pe_out[1], 0);
        chk("rst_pe_out0", pe_out[0], 0);
        chk("rst_done", compute_done, 0);
        chk("rst_load_done", load_done, 0);

        do_start(1'b0, 1'b0, 0, 0, 0);
        chk("noload_pe_out2", pe_out[2], 0);
        chk("noload_load_done", load_done, 0);

        load_w(1'b0);
        chk("wonly_load_done", load_done, 0);
        do_start(1'b0, 1'b0, 0, 0, 0);
        chk("wonly_pe_out2", pe_out[2], 0);

        load_a(1'b0);
        chk("load_done_last_word", load_done, 0);
        tick(1);
        chk("load_done_rise", load_done, 1);

        do_start(1'b1, 1'b1, 16'd411, 16'd456, 16'd501);
        do_start(1'b1, 1'b1, 16'd636, 16'd681, 16'd726);
        do_start(1'b1, 1'b1, 16'd861, 16'd906, 16'd951);
        do_start(1'b1, 1'b1, 16'd411, 16'd456, 16'd501);
        do_start(1'b1, 1'b1, 16'd636, 16'd681, 16'd726);

        load_a(1'b0);
        tick(1);
        do_start(1'b1, 1'b1, 16'd411, 16'd456, 16'd501);

        push_exp(1'b0, 0, 0, 0);
        start = 1'b1;
        tick(3);
        start = 1'b0;
        tick(6);
        chk("hold_sb_drained", sb.size(), 0);

        push_exp(1'b0, 0, 0, 0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(6);
        chk("dbl_sb_drained", sb.size(), 0);

        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        r_m   = 0;
        chk("abort_pe_out2", pe_out[2], 0);
        chk("abort_pe_out0", pe_out[0], 0);
        chk("abort_done", compute_done, 0);
        chk("abort_load_done", load_done, 0);
        tick(6);
        do_start(1'b0, 1'b0, 0, 0, 0);
        chk("abort_ignored_pe_out1", pe_out[1], 0);
        load_w(1'b0);
        do_start(1'b0, 1'b0, 0, 0, 0);
        load_a(1'b0);
        tick(1);
        chk("reload_load_done", load_done, 1);
        do_start(1'b1, 1'b1, 16'd411, 16'd456, 16'd501);

        load_w(1'b1);
        load_a(1'b1);
        tick(1);
        do_start(1'b1, 1'b1, 16'd9, 16'd9, 16'd9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
